// File: rtl/display_arb_pkg.sv
// display_arb_pkg
//   Shared definitions for the display arbiter slice: arbiter state
//   encoding, payload width, owner index width and a ceil-log2 helper
//   used to size the dwell counter.
package display_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int unsigned DISPLAY_WIDTH = 32;
    localparam int unsigned OWNER_WIDTH   = 3;

    // Smallest width w with 2**w >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        longint unsigned span;
        width = 0;
        span  = 1;
        while (span < longint'(value)) begin
            span  = span << 1;
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin search. Scans the request vector starting
//   at 'start' and wrapping at NUM_REQ-1 -> 0, skipping any index set in
//   'exclude'. Reports the first hit.
// Ports:
//   req      in   NUM_REQ       request vector
//   start    in   OWNER_WIDTH   first index to examine
//   exclude  in   NUM_REQ       indices that may not win
//   winner   out  OWNER_WIDTH   index of the first eligible request
//   found    out  1             an eligible request exists
module rr_pick
    import display_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]     req,
    input  logic [OWNER_WIDTH-1:0] start,
    input  logic [NUM_REQ-1:0]     exclude,
    output logic [OWNER_WIDTH-1:0] winner,
    output logic                   found
);

    logic [NUM_REQ-1:0] cand;

    assign cand = req & ~exclude;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Shift the candidate down to bit 0 rather than indexing, so the
            // index width never has to match the vector width.
            if (!found &&
                ((cand >> ((32'(start) + k) % NUM_REQ)) & NUM_REQ'(1)) != '0) begin
                found  = 1'b1;
                winner = OWNER_WIDTH'((32'(start) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// display_arbiter
//   Shares one 8-digit display among NUM_REQ requesters. A grantee keeps
//   the display for at least DWELL_CYCLES cycles while others wait, is
//   released immediately when it drops its request, and keeps it
//   indefinitely when nobody else asks. Selection is round-robin from the
//   index after the last owner. All outputs are registered.
// Ports:
//   clk            in   1                  system clock
//   rst            in   1                  asynchronous active-high reset
//   req            in   NUM_REQ            level-sensitive requests
//   req_data       in   32*NUM_REQ         payloads, requester i at [32*i +: 32]
//   gnt            out  NUM_REQ            one-hot grant, zero when idle
//   owner          out  3                  current grantee (valid with display_valid)
//   display_data   out  32                 payload of the current grantee
//   display_valid  out  1                  display is owned
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DWELL_CYCLES = 6000000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [DISPLAY_WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [OWNER_WIDTH-1:0]           owner,
    output logic [DISPLAY_WIDTH-1:0]         display_data,
    output logic                             display_valid
);

    localparam int unsigned       CNT_W      = clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    arb_state_t               state, state_d;
    logic                     armed;
    logic [OWNER_WIDTH-1:0]   last_owner, owner_d;
    logic [OWNER_WIDTH-1:0]   rr_start, rr_winner;
    logic                     rr_found;
    logic [NUM_REQ-1:0]       owner_mask, rr_exclude, gnt_d;
    logic                     owner_req, dwell_done, take_grant;
    logic [CNT_W-1:0]         dwell_cnt;
    logic [DISPLAY_WIDTH-1:0] data_d;

    assign owner_mask = NUM_REQ'(1) << owner;
    assign owner_req  = |(req & owner_mask);
    assign dwell_done = (dwell_cnt == DWELL_LAST);
    assign rr_start   = OWNER_WIDTH'((32'(last_owner) + 1) % NUM_REQ);
    // While owned, the current owner is never a handover target.
    assign rr_exclude = (state == OWNED) ? owner_mask : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req     (req),
        .start   (rr_start),
        .exclude (rr_exclude),
        .winner  (rr_winner),
        .found   (rr_found)
    );

    // State register. 'armed' delays arbitration by one edge after reset
    // release so deassertion is absorbed synchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_d;
            armed <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state;
        owner_d    = owner;
        take_grant = 1'b0;
        case (state)
            IDLE: begin
                if (armed && rr_found) begin
                    state_d    = OWNED;
                    owner_d    = rr_winner;
                    take_grant = 1'b1;
                end
            end
            OWNED: begin
                if (!owner_req || dwell_done) begin
                    if (rr_found) begin
                        owner_d    = rr_winner;
                        take_grant = 1'b1;
                    end else if (!owner_req) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs. Data is taken
    // from the next owner so a handover shows new data on the same edge.
    always_comb begin
        gnt_d  = '0;
        data_d = display_data;
        if (state_d == OWNED) begin
            gnt_d = NUM_REQ'(1) << owner_d;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (32'(owner_d) == i) begin
                    data_d = req_data[DISPLAY_WIDTH*i +: DISPLAY_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner        <= '0;
            last_owner   <= OWNER_WIDTH'(NUM_REQ - 1);
            dwell_cnt    <= '0;
            gnt          <= '0;
            display_data <= '0;
        end else begin
            owner        <= owner_d;
            gnt          <= gnt_d;
            display_data <= data_d;
            if (take_grant) begin
                last_owner <= owner_d;
                dwell_cnt  <= '0;
            end else if (state == OWNED && !dwell_done) begin
                dwell_cnt <= dwell_cnt + CNT_W'(1);
            end
        end
    end

    assign display_valid = (state == OWNED);

endmodule
